// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) constants, FSM encoding and affine helpers for the AES S-box engines.
package aes_gf_pkg;

    localparam logic [8:0] GF_POLY_DEFAULT = 9'h11B;
    localparam logic [7:0] INV_AFFINE_C    = 8'h05;
    localparam logic [7:0] FWD_AFFINE_C    = 8'h63;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_STEP  = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_t;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ INV_AFFINE_C;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] v);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ FWD_AFFINE_C;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiply: carry-less 8x8 product reduced by GF_POLY.
// Zero latency, no handshake.
module gf256_mul
    import aes_gf_pkg::*;
#(
    parameter logic [8:0] GF_POLY = GF_POLY_DEFAULT
) (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);

    logic [14:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b_i[i]) prod = prod ^ (15'(a_i) << i);
        end
        // Clear bits 14..8 from the top down so each fold sees the updated upper bits.
        for (int k = 14; k >= 8; k--) begin
            if (prod[k]) prod = prod ^ (15'(GF_POLY) << (k - 8));
        end
        p_o = prod[7:0];
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes: one byte per 8 cycles via a^254 square-and-multiply; out_valid 8*NUM_BYTES cycles after accept.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. FWD_SBOX_EN adds a mode port for forward SubBytes.
module inv_sub_bytes_seq
    import aes_gf_pkg::*;
#(
    parameter int         NUM_BYTES = 16,
    parameter logic [8:0] GF_POLY   = GF_POLY_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef FWD_SBOX_EN
    input  logic                   mode,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] state_out
);

    localparam int W     = 8 * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [2:0]       LAST_STEP = 3'd5;

    fsm_state_t       state_q;
    logic [W-1:0]     hold_q;
    logic [W-1:0]     result_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       step_q;
    logic [7:0]       base_q;
    logic [7:0]       x_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             fwd_sel;

    logic [7:0] cur_byte;
    logic [7:0] base_d;
    logic [7:0] sq_x;
    logic [7:0] x_d;
    logic [7:0] sq_final;
    logic [7:0] res_byte;

`ifdef FWD_SBOX_EN
    logic fwd_q;
    assign fwd_sel = fwd_q;
`else
    assign fwd_sel = 1'b0;
`endif

    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) cur_byte = hold_q[8*(NUM_BYTES-1-i) +: 8];
        end
    end

    assign base_d = fwd_sel ? cur_byte : inv_affine(cur_byte);

    // x <- x^2 * base per step; after six steps x = base^127.
    gf256_mul #(.GF_POLY(GF_POLY)) u_step_sq  (.a_i(x_q),  .b_i(x_q),    .p_o(sq_x));
    gf256_mul #(.GF_POLY(GF_POLY)) u_step_mul (.a_i(sq_x), .b_i(base_q), .p_o(x_d));
    gf256_mul #(.GF_POLY(GF_POLY)) u_final_sq (.a_i(x_q),  .b_i(x_q),    .p_o(sq_final));

    assign res_byte = fwd_sel ? fwd_affine(sq_final) : sq_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            step_q      <= '0;
            base_q      <= '0;
            x_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FWD_SBOX_EN
            fwd_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        hold_q     <= state_in;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_LOAD;
`ifdef FWD_SBOX_EN
                        fwd_q      <= mode;
`endif
                    end
                end
                ST_LOAD: begin
                    base_q  <= base_d;
                    x_q     <= base_d;
                    step_q  <= '0;
                    state_q <= ST_STEP;
                end
                ST_STEP: begin
                    x_q    <= x_d;
                    step_q <= step_q + 3'd1;
                    if (step_q == LAST_STEP) state_q <= ST_FINAL;
                end
                ST_FINAL: begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (idx_q == IDX_W'(i)) result_q[8*(NUM_BYTES-1-i) +: 8] <= res_byte;
                    end
                    if (idx_q == LAST_IDX) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign state_out = result_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq with an independent S-box reference and an expected-result queue.
module tb_inv_sub_bytes_seq;

    localparam int NB = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [8*NB-1:0] state_in;
    logic           out_valid;
    logic           out_ready;
    logic [8*NB-1:0] state_out;
`ifdef FWD_SBOX_EN
    logic           mode;
`endif

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FWD_SBOX_EN
        .mode      (mode),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    int   checks = 0;
    int   errors = 0;
    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];
    logic [8*NB-1:0] exp_q [$];
    time  acc_t;

    task automatic chk(input string tag, input logic [8*NB-1:0] obs, input logic [8*NB-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Shift-and-add multiply with xtime reduction, independent of the DUT's structure.
    function automatic logic [7:0] xmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
        end
        return r;
    endfunction

    function automatic logic [8*NB-1:0] model(input logic [8*NB-1:0] s, input logic fwd);
        logic [8*NB-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++)
            r[8*i +: 8] = fwd ? sbox[s[8*i +: 8]] : isbox[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [8*NB-1:0] rnd_state();
        logic [8*NB-1:0] r;
        for (int i = 0; i < NB / 4; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic send(input logic [8*NB-1:0] s, input logic m, input logic [8*NB-1:0] expv, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {127'b0, (n < 300)}, 128'd1);
        in_valid = 1'b1;
        state_in = s;
`ifdef FWD_SBOX_EN
        mode = m;
`endif
        @(posedge clk);
        acc_t = $time;
        @(negedge clk);
        in_valid = 1'b0;
        state_in = rnd_state();
`ifdef FWD_SBOX_EN
        mode = ~m;
`endif
        if (push) exp_q.push_back(expv);
    endtask

    task automatic wait_out(output bit ok);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = (out_valid === 1'b1);
        chk("out_valid_timeout", {127'b0, ok}, 128'd1);
        if (ok) chk("latency", 128'(($time - 5 - acc_t) / 10), 128'd128);
    endtask

    task automatic recv(input string tag);
        bit ok;
        logic [8*NB-1:0] e;
        out_ready = 1'b1;
        wait_out(ok);
        if (ok) begin
            e = exp_q.pop_front();
            chk(tag, state_out, e);
            @(negedge clk);
            chk("out_valid_drop", {127'b0, out_valid}, 128'd0);
            chk("in_ready_after", {127'b0, in_ready}, 128'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*NB-1:0] a_s, b_s, snap, fw_in, fw_out;
        logic [7:0] inv, y;
        bit ok, seen;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (x != 0 && xmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            for (int i = 0; i < 8; i++)
                y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox[x] = y ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; state_in = '0;
`ifdef FWD_SBOX_EN
        mode = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_after", {127'b0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_state_out", state_out, 128'd0);

        send({NB{8'h63}}, 1'b0, 128'd0, 1'b1);
        recv("all_63");

        send({8'h00, 8'h7C, 8'h16, 8'hED, 8'h63, 8'h52, {10{8'h63}}}, 1'b0,
             {8'h52, 8'h01, 8'hFF, 8'h53, 8'h00, 8'h48, {10{8'h00}}}, 1'b1);
        recv("mixed_bytes");

        for (int t = 0; t < 3; t++) begin
            a_s = rnd_state();
            send(a_s, 1'b0, model(a_s, 1'b0), 1'b1);
            recv("random_state");
        end

        // Backpressure: hold result, try a second request while busy.
        a_s = rnd_state();
        b_s = rnd_state();
        out_ready = 1'b0;
        send(a_s, 1'b0, model(a_s, 1'b0), 1'b1);
        wait_out(ok);
        snap = state_out;
        chk("bp_result", snap, exp_q.pop_front());
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                in_valid = 1'b1;
                state_in = b_s;
            end
            @(negedge clk);
            chk("bp_stable", state_out, snap);
            chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
            chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_drop", {127'b0, out_valid}, 128'd0);
        chk("bp_bubble_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk);
        acc_t = $time;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accept_next", {127'b0, in_ready}, 128'd0);
        exp_q.push_back(model(b_s, 1'b0));
        recv("bp_second");

        // Reset mid-transaction discards the partial result.
        send(rnd_state(), 1'b0, '0, 1'b0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state_out", state_out, 128'd0);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_valid", {127'b0, seen}, 128'd0);
        chk("midrst_state_out_held", state_out, 128'd0);
        a_s = rnd_state();
        send(a_s, 1'b0, model(a_s, 1'b0), 1'b1);
        recv("after_midrst");

`ifdef FWD_SBOX_EN
        fw_in  = {8'h00, 8'h01, 8'h53, 8'hFF, {12{8'h00}}};
        fw_out = {8'h63, 8'h7C, 8'hED, 8'h16, {12{8'h63}}};
        send(fw_in, 1'b1, fw_out, 1'b1);
        recv("fwd_mode");
        send(fw_out, 1'b0, fw_in, 1'b1);
        recv("fwd_roundtrip");
`else
        fw_in  = '0;
        fw_out = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
